hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Hazard/forwarding controller that drives the select codes of the D/E/M operand forwarding muxes.
//  Tracks each in-flight instruction's destination register, result source and Tnew.
//  Tracking runs through internal E/M/W shadow stages, in lock-step with the datapath pipeline registers.
//  Compares the D-stage operands (with their Tuse) against those stages.
//  Emits stall, or the forwarding source per operand.
// PARAMETERS
//  RA_W    5   register-address width
//  CNT_W   32  stall-counter width (only with HAZ_PERF_CNT_EN)
// PORTS
//  clk         in   1      pipeline clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  rs_D        in   RA_W   D-stage rs address
//  rt_D        in   RA_W   D-stage rt address
//  tuse_rs_D   in   2      cycles until rs is needed: 0=D, 1=E, 2=M, 3=unused
//  tuse_rt_D   in   2      same for rt
//  dst_D       in   RA_W   D-stage write register (0 = no write)
//  res_D       in   2      result source: 0=none, 1=ALU, 2=MEM, 3=PC+8
//  stall       out  1      freeze PC and IF/ID; bubble into E
//  selRsD      out  3      0 grf, 1 pc_E8, 2 pc_M8, 3 aluRet_M, 4 pc_W8, 5 writeData_W
//  selRtD      out  3      same encoding as selRsD
//  selRsE      out  3      0 rsD_E, 1 pc_M8, 2 aluRet_M, 3 pc_W8, 4 writeData_W
//  selRtE      out  3      same encoding as selRsE
//  selRtM      out  3      0 rt_M, 1 pc_W8, 2 writeData_W
//  stall_cnt   out  CNT_W  stall cycles since reset (only with HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  State: per-stage entry {rs, rt, dst, res, tnew} for E, M and W (W holds dst/res only).
//   - Tnew on entry to E: PC+8 = 0, ALU = 1, MEM = 2, none = 0.
//  Each clk edge:
//   - W <= M; M <= E with tnew = sat-dec(tnew).
//   - E <= D-entry, or bubble (all fields 0) when stall = 1.
//  Entry is valid when dst != 0 and res != 0; a bubble or dst == 0 never matches and never forwards.
//  Stall: an operand with tuse != 3 hazards if any valid stage entry has dst == operand address
//   and stage tnew > tuse.
//   - Stage tnew: E = tnew_E; M = sat-dec(tnew_E at entry); W = 0.
//   - stall = OR of the rs and rt hazards; combinational from current state and D inputs.
//  Forward priority is nearest stage first: E > M > W > register file.
//   - Only the nearest matching entry is considered; if it is not ready, select 0 (stall covers it).
//  selRs/RtD match per stage:
//   - E entry, PC+8 -> 1.
//   - M entry: PC+8 -> 2; ALU -> 3; MEM -> not ready.
//   - W entry: PC+8 -> 4; ALU/MEM -> 5.
//   - No match -> 0.
//  selRs/RtE compare the E entry's rs/rt against M and W, same rules: M PC+8 -> 1, M ALU -> 2,
//   W PC+8 -> 3, W ALU/MEM -> 4, otherwise 0.
//  selRtM compares the M entry's rt against W: PC+8 -> 1, ALU/MEM -> 2, otherwise 0.
//  Address 0 is never forwarded, even if some stage claims dst 0.
//  Latency: selects and stall are combinational in the same cycle; state updates one cycle later.
//  Reset (async, reset_n = 0): all stage entries cleared to bubble.
//   - Outputs then read stall = 0 and all sel = 0; reset mid-stall drops the stall immediately.
//  Stall lasts as many cycles as needed; E receives one bubble per stalled cycle.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - stall_cnt port present; increments on each clk edge with stall = 1.
//   - Saturates at all-ones; cleared by reset_n.
//  HAZ_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. add $1 (ALU) then add $2,$1,$1 (tuse 1): in D, stall = 0.
//     Next cycle selRsE = selRtE = 2 (aluRet_M).
//  2. lw $3 (MEM) then beq $3,$0 (tuse 0): stall = 1 for 2 cycles, 2 bubbles into E.
//     Then selRsD = 5 (writeData_W).
//  3. jal (PC+8, dst 31) then jr $31 (tuse 0): stall = 0 and selRsD = 1 (pc_E8) in the same cycle.
//  4. lw $4, then sw $4 (rt tuse 2) directly behind it: stall = 0.
//     When sw is in M, selRtM = 2 (writeData_W).
//  5. Writes to $0 in E/M/W plus a reader of $0 (tuse 0): stall = 0, selRsD = 0.
//  6. reset_n low during stall: stall and all sel go 0 asynchronously.
//     With HAZ_PERF_CNT_EN, stall_cnt = 0 after reset and = 2 after scenario 2.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage hazard/forwarding bus: D-stage operand info in, stall and forwarding selects out.
// stall_cnt exists only when HAZ_PERF_CNT_EN is defined.
interface hazard_fwd_ctrl_if #(
  parameter int RA_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic [RA_W-1:0] rs_D;
  logic [RA_W-1:0] rt_D;
  logic [1:0]      tuse_rs_D;
  logic [1:0]      tuse_rt_D;
  logic [RA_W-1:0] dst_D;
  logic [1:0]      res_D;
  logic            stall;
  logic [2:0]      selRsD;
  logic [2:0]      selRtD;
  logic [2:0]      selRsE;
  logic [2:0]      selRtE;
  logic [2:0]      selRtM;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, res_D,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt,
`endif
    input  stall, selRsD, selRtD, selRsE, selRtE, selRtM
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, res_D,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt,
`endif
    output stall, selRsD, selRtD, selRsE, selRtE, selRtM
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: shadows E/M/W destination info and drives stall plus forwarding selects.
// Define HAZ_PERF_CNT_EN to add the saturating stall-cycle counter (stall_cnt).
module hazard_fwd_ctrl #(
  parameter int RA_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic              clk,
  input logic              reset_n,
  hazard_fwd_ctrl_if.slave bus
);
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_ALU  = 2'd1;
  localparam logic [1:0] RES_MEM  = 2'd2;
  localparam logic [1:0] RES_PC8  = 2'd3;

  logic [RA_W-1:0] e_rs_reg, e_rt_reg, e_dst_reg;
  logic [1:0]      e_res_reg, e_tnew_reg;
  logic [RA_W-1:0] m_rt_reg, m_dst_reg;
  logic [1:0]      m_res_reg, m_tnew_reg;
  logic [RA_W-1:0] w_dst_reg;
  logic [1:0]      w_res_reg;

  logic [1:0] tnew_d;
  logic       e_valid, m_valid, w_valid;
  logic       stall;

  always_comb begin
    case (bus.res_D)
      RES_ALU: tnew_d = 2'd1;
      RES_MEM: tnew_d = 2'd2;
      default: tnew_d = 2'd0;
    endcase
  end

  // A zero destination or no result never matches, so register 0 is never forwarded.
  assign e_valid = (e_dst_reg != '0) && (e_res_reg != RES_NONE);
  assign m_valid = (m_dst_reg != '0) && (m_res_reg != RES_NONE);
  assign w_valid = (w_dst_reg != '0) && (w_res_reg != RES_NONE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_d_op
      logic [RA_W-1:0] addr;
      logic [1:0]      tuse;
      logic            e_hit, m_hit, w_hit, hazard;
      logic [2:0]      sel;

      assign addr  = (gi == 0) ? bus.rs_D : bus.rt_D;
      assign tuse  = (gi == 0) ? bus.tuse_rs_D : bus.tuse_rt_D;
      assign e_hit = e_valid && (e_dst_reg == addr);
      assign m_hit = m_valid && (m_dst_reg == addr);
      assign w_hit = w_valid && (w_dst_reg == addr);
      // W always has tnew 0, so it can never cause a stall.
      assign hazard = (tuse != 2'd3) &&
                      ((e_hit && (e_tnew_reg > tuse)) || (m_hit && (m_tnew_reg > tuse)));

      always_comb begin
        sel = 3'd0;
        if (e_hit) begin
          if (e_res_reg == RES_PC8) sel = 3'd1;
        end else if (m_hit) begin
          case (m_res_reg)
            RES_PC8: sel = 3'd2;
            RES_ALU: sel = 3'd3;
            default: sel = 3'd0;
          endcase
        end else if (w_hit) begin
          sel = (w_res_reg == RES_PC8) ? 3'd4 : 3'd5;
        end
      end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_e_op
      logic [RA_W-1:0] addr;
      logic            m_hit, w_hit;
      logic [2:0]      sel;

      assign addr  = (gi == 0) ? e_rs_reg : e_rt_reg;
      assign m_hit = m_valid && (m_dst_reg == addr);
      assign w_hit = w_valid && (w_dst_reg == addr);

      always_comb begin
        sel = 3'd0;
        if (m_hit) begin
          case (m_res_reg)
            RES_PC8: sel = 3'd1;
            RES_ALU: sel = 3'd2;
            default: sel = 3'd0;
          endcase
        end else if (w_hit) begin
          sel = (w_res_reg == RES_PC8) ? 3'd3 : 3'd4;
        end
      end
    end
  endgenerate

  logic       m_w_hit;
  logic [2:0] sel_rt_m;

  assign m_w_hit  = w_valid && (w_dst_reg == m_rt_reg);
  assign sel_rt_m = !m_w_hit ? 3'd0 : ((w_res_reg == RES_PC8) ? 3'd1 : 3'd2);

  assign stall      = g_d_op[0].hazard | g_d_op[1].hazard;
  assign bus.stall  = stall;
  assign bus.selRsD = g_d_op[0].sel;
  assign bus.selRtD = g_d_op[1].sel;
  assign bus.selRsE = g_e_op[0].sel;
  assign bus.selRtE = g_e_op[1].sel;
  assign bus.selRtM = sel_rt_m;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rs_reg   <= '0;
      e_rt_reg   <= '0;
      e_dst_reg  <= '0;
      e_res_reg  <= '0;
      e_tnew_reg <= '0;
      m_rt_reg   <= '0;
      m_dst_reg  <= '0;
      m_res_reg  <= '0;
      m_tnew_reg <= '0;
      w_dst_reg  <= '0;
      w_res_reg  <= '0;
    end else begin
      w_dst_reg  <= m_dst_reg;
      w_res_reg  <= m_res_reg;
      m_rt_reg   <= e_rt_reg;
      m_dst_reg  <= e_dst_reg;
      m_res_reg  <= e_res_reg;
      m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
      // A stalled D instruction stays put; E takes a bubble instead.
      if (stall) begin
        e_rs_reg   <= '0;
        e_rt_reg   <= '0;
        e_dst_reg  <= '0;
        e_res_reg  <= '0;
        e_tnew_reg <= '0;
      end else begin
        e_rs_reg   <= bus.rs_D;
        e_rt_reg   <= bus.rt_D;
        e_dst_reg  <= bus.dst_D;
        e_res_reg  <= bus.res_D;
        e_tnew_reg <= tnew_d;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed pipeline table, async reset mid-stall, then random traffic
// checked against an age-based pipeline model.
`timescale 1ns/1ps
module tb_hazard_fwd_ctrl;
  localparam int RA_W = 5;
  localparam int NV   = 27;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.RA_W(RA_W)) bus ();
  hazard_fwd_ctrl #(.RA_W(RA_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic [4:0] dst;
    logic [1:0] res;
  } din_t;

  typedef struct packed {
    din_t       d;
    logic       st;
    logic [2:0] srsd, srtd, srse, srte, srtm;
  } vec_t;

  typedef struct packed {
    logic [4:0] rs, rt, dst;
    logic [1:0] res;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  vec_t vecs [NV];
  ent_t hist [$];   // hist[k] = instruction that entered E k cycles ago

  string d_src [6] = '{"grf", "pc_E8", "pc_M8", "aluRet_M", "pc_W8", "writeData_W"};
  string e_src [5] = '{"rsD_E", "pc_M8", "aluRet_M", "pc_W8", "writeData_W"};
  string m_src [3] = '{"rt_M", "pc_W8", "writeData_W"};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input int a, input int b,
                          input int c, input int d, input int e);
    chk({tag, ".stall"},  int'(bus.stall),  st);
    chk({tag, ".selRsD"}, int'(bus.selRsD), a);
    chk({tag, ".selRtD"}, int'(bus.selRtD), b);
    chk({tag, ".selRsE"}, int'(bus.selRsE), c);
    chk({tag, ".selRtE"}, int'(bus.selRtE), d);
    chk({tag, ".selRtM"}, int'(bus.selRtM), e);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, int'(bus.stall_cnt), exp_cnt);
`endif
  endtask

  task automatic drive(input din_t d);
    bus.rs_D = d.rs;  bus.rt_D = d.rt;
    bus.tuse_rs_D = d.trs;  bus.tuse_rt_D = d.trt;
    bus.dst_D = d.dst;  bus.res_D = d.res;
  endtask

  function automatic vec_t mk(int rs, int rt, int trs, int trt, int dst, int res,
                              int st, int a, int b, int c, int d, int e);
    vec_t v;
    v.d    = '{rs: 5'(rs), rt: 5'(rt), trs: 2'(trs), trt: 2'(trt), dst: 5'(dst), res: 2'(res)};
    v.st   = 1'(st);
    v.srsd = 3'(a); v.srtd = 3'(b); v.srse = 3'(c); v.srte = 3'(d); v.srtm = 3'(e);
    return v;
  endfunction

  // ---- reference model: result readiness from latency minus age ----
  function automatic bit mvalid(ent_t e);
    return (e.dst != 0) && (e.res != 0);
  endfunction

  function automatic int cycles_left(logic [1:0] res, int age);
    int lat;
    lat = (res == 2'd1) ? 1 : (res == 2'd2) ? 2 : 0;
    return (lat - age > 0) ? lat - age : 0;
  endfunction

  function automatic string src_name(int age, logic [1:0] res);
    string stg [3] = '{"E", "M", "W"};
    if (res == 2'd3) return {"pc_", stg[age], "8"};
    if (age == 1 && res == 2'd1) return "aluRet_M";
    if (age == 2) return "writeData_W";
    return "";
  endfunction

  function automatic int code_of(string s, int mux);
    if (mux == 0) begin for (int i = 1; i < 6; i++) if (d_src[i] == s) return i; end
    else if (mux == 1) begin for (int i = 1; i < 5; i++) if (e_src[i] == s) return i; end
    else begin for (int i = 1; i < 3; i++) if (m_src[i] == s) return i; end
    return 0;
  endfunction

  function automatic int exp_sel(logic [4:0] a, int from, int mux);
    for (int i = from; i < hist.size(); i++)
      if (mvalid(hist[i]) && hist[i].dst == a) return code_of(src_name(i, hist[i].res), mux);
    return 0;
  endfunction

  function automatic bit op_hazard(logic [4:0] a, logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    for (int i = 0; i < hist.size(); i++)
      if (mvalid(hist[i]) && hist[i].dst == a && cycles_left(hist[i].res, i) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall(din_t d);
    return op_hazard(d.rs, d.trs) || op_hazard(d.rt, d.trt);
  endfunction

  task automatic model_advance(input din_t d, input bit st);
    ent_t e;
    e = st ? '0 : '{rs: d.rs, rt: d.rt, dst: d.dst, res: d.res};
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    if (st) exp_cnt++;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    din_t cur, nop;
    bit   ms, prev_stall;
    int   e_rs, e_rt, m_rt;

    nop = '{rs: 5'd0, rt: 5'd0, trs: 2'd3, trt: 2'd3, dst: 5'd0, res: 2'd0};
    //            rs  rt trs trt dst res | st rsD rtD rsE rtE rtM
    vecs[0]  = mk( 0,  0, 3, 3,  1, 1,   0, 0, 0, 0, 0, 0);  // add $1
    vecs[1]  = mk( 1,  1, 1, 1,  2, 1,   0, 0, 0, 0, 0, 0);  // add $2,$1,$1
    vecs[2]  = mk( 0,  0, 3, 3,  0, 0,   0, 0, 0, 2, 2, 0);
    vecs[3]  = mk( 0,  0, 3, 3,  3, 2,   0, 0, 0, 0, 0, 2);  // lw $3
    vecs[4]  = mk( 3,  0, 0, 0,  0, 0,   1, 0, 0, 0, 0, 0);  // beq $3,$0
    vecs[5]  = mk( 3,  0, 0, 0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[6]  = mk( 3,  0, 0, 0,  0, 0,   0, 5, 0, 0, 0, 0);
    vecs[7]  = mk( 0,  0, 3, 3, 31, 3,   0, 0, 0, 0, 0, 0);  // jal
    vecs[8]  = mk(31,  0, 0, 3,  0, 0,   0, 1, 0, 0, 0, 0);  // jr $31
    vecs[9]  = mk( 0,  0, 3, 3,  4, 2,   0, 0, 0, 1, 0, 0);  // lw $4
    vecs[10] = mk( 0,  4, 3, 2,  0, 0,   0, 0, 0, 0, 0, 0);  // sw $4
    vecs[11] = mk( 0,  0, 3, 3,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[12] = mk( 0,  0, 3, 3,  0, 0,   0, 0, 0, 0, 0, 2);
    vecs[13] = mk( 0,  0, 3, 3,  0, 1,   0, 0, 0, 0, 0, 0);  // writes to $0
    vecs[14] = mk( 0,  0, 3, 3,  0, 1,   0, 0, 0, 0, 0, 0);
    vecs[15] = mk( 0,  0, 3, 3,  0, 1,   0, 0, 0, 0, 0, 0);
    vecs[16] = mk( 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0);  // reader of $0
    vecs[17] = mk( 0,  0, 3, 3, 31, 3,   0, 0, 0, 0, 0, 0);  // jal
    vecs[18] = mk( 0,  0, 3, 3,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[19] = mk(31,  0, 0, 3,  0, 0,   0, 2, 0, 0, 0, 0);
    vecs[20] = mk( 0, 31, 3, 1,  0, 0,   0, 0, 4, 3, 0, 0);
    vecs[21] = mk( 0,  0, 3, 3,  6, 1,   0, 0, 0, 0, 0, 0);  // add $6
    vecs[22] = mk( 0,  0, 3, 3,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[23] = mk( 6,  0, 0, 3,  0, 0,   0, 3, 0, 0, 0, 0);
    vecs[24] = mk( 0,  0, 3, 3,  7, 1,   0, 0, 0, 4, 0, 0);  // add $7
    vecs[25] = mk( 7,  7, 0, 1,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[26] = mk( 7,  7, 0, 1,  0, 0,   0, 3, 3, 0, 0, 0);

    drive(nop);
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].d);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].srsd), int'(vecs[i].srtd),
               int'(vecs[i].srse), int'(vecs[i].srte), int'(vecs[i].srtm));
      $display("vec%0d rs=%0d rt=%0d dst=%0d res=%0d -> stall=%0d sel=%0d/%0d/%0d/%0d/%0d", i,
               vecs[i].d.rs, vecs[i].d.rt, vecs[i].d.dst, vecs[i].d.res, bus.stall,
               bus.selRsD, bus.selRtD, bus.selRsE, bus.selRtE, bus.selRtM);
      if (vecs[i].st) exp_cnt++;
      @(posedge clk); #1;
    end

    // Reset asserted while a load-use stall is active.
    drive('{rs: 5'd0, rt: 5'd0, trs: 2'd3, trt: 2'd3, dst: 5'd9, res: 2'd2});
    @(posedge clk); #1;
    drive('{rs: 5'd9, rt: 5'd0, trs: 2'd0, trt: 2'd3, dst: 5'd0, res: 2'd0});
    @(negedge clk);
    chk("rst_pre.stall", int'(bus.stall), 1);
    #1 reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk_outs("rst_async", 0, 0, 0, 0, 0, 0);
    $display("reset mid-stall -> stall=%0d", bus.stall);
    drive(nop);
    @(posedge clk);
    @(negedge clk);
    chk_outs("rst_held", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    hist.delete();

    prev_stall = 1'b0;
    cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        cur.rs  = rand_addr();  cur.rt  = rand_addr();
        cur.trs = 2'($urandom_range(0, 3));  cur.trt = 2'($urandom_range(0, 3));
        cur.dst = rand_addr();  cur.res = 2'($urandom_range(0, 3));
      end
      drive(cur);
      @(negedge clk);
      ms   = model_stall(cur);
      e_rs = (hist.size() > 0) ? exp_sel(hist[0].rs, 1, 1) : 0;
      e_rt = (hist.size() > 0) ? exp_sel(hist[0].rt, 1, 1) : 0;
      m_rt = (hist.size() > 1) ? exp_sel(hist[1].rt, 2, 2) : 0;
      chk_outs($sformatf("rnd%0d", n), int'(ms), exp_sel(cur.rs, 0, 0), exp_sel(cur.rt, 0, 0),
               e_rs, e_rt, m_rt);
      $display("rnd%0d rs=%0d/%0d rt=%0d/%0d dst=%0d res=%0d -> stall=%0d sel=%0d/%0d/%0d/%0d/%0d",
               n, cur.rs, cur.trs, cur.rt, cur.trt, cur.dst, cur.res, bus.stall,
               bus.selRsD, bus.selRtD, bus.selRsE, bus.selRtE, bus.selRtM);
      @(posedge clk);
      model_advance(cur, ms);
      prev_stall = ms;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
